// File: rtl/bsg_manycore_tag_boot_pkg.sv
// Shared types and header geometry for the bsg_tag boot sequencer.
package bsg_manycore_tag_boot_pkg;

   localparam int unsigned tag_boot_node_id_width_lp     = 8;
   localparam int unsigned tag_boot_max_payload_width_lp = 16;
   localparam int unsigned tag_boot_lg_payload_width_lp  = 5;

   // start bit + len + data_not_reset + node_id
   localparam int unsigned tag_boot_hdr_len_lp =
      2 + tag_boot_lg_payload_width_lp + tag_boot_node_id_width_lp;

   typedef struct packed {
      logic                                     last;
      logic [tag_boot_node_id_width_lp-1:0]     node_id;
      logic                                     data_not_reset;
      logic [tag_boot_lg_payload_width_lp-1:0]  len;
      logic [tag_boot_max_payload_width_lp-1:0] payload;
   } bsg_manycore_tag_boot_entry_s;

   localparam int unsigned tag_boot_entry_width_lp = $bits(bsg_manycore_tag_boot_entry_s);

   typedef enum logic [2:0] {
      s_idle,
      s_pre,
      s_load,
      s_hdr,
      s_pay,
      s_gap,
      s_done
   } tag_boot_state_e;

   function automatic int unsigned tag_boot_hdr_len(input int unsigned lg_payload_width,
                                                    input int unsigned node_id_width);
      return 2 + lg_payload_width + node_id_width;
   endfunction

   function automatic int unsigned tag_boot_max(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/bsg_manycore_tag_boot_shifter.sv
// Parallel-load, LSB-first shift register with a down-counter of remaining bits.
// shift_o is registered and holds the bit currently on the wire; it returns to 0
// once the loaded bits are exhausted. empty_o is high while the final bit (or
// nothing) is being driven, so the owner can reload on that same edge.
module bsg_manycore_tag_boot_shifter
   import bsg_manycore_tag_boot_pkg::*;
 #(parameter int unsigned width_p = tag_boot_max_payload_width_lp
  ,localparam int unsigned cnt_width_lp = $clog2(width_p + 1)
  )
  (input  logic                    clk_i
  ,input  logic                    reset_i
  ,input  logic                    load_i
  ,input  logic [width_p-1:0]      data_i
  ,input  logic [cnt_width_lp-1:0] len_i
  ,output logic                    shift_o
  ,output logic                    empty_o
  );

   logic [width_p-1:0]      data_r;
   logic [cnt_width_lp-1:0] cnt_r;

   // Load presents bit 0 immediately; each later edge moves the next bit out.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         data_r  <= '0;
         cnt_r   <= '0;
         shift_o <= 1'b0;
      end else if (load_i) begin
         shift_o <= (len_i != '0) & data_i[0];
         data_r  <= data_i >> 1;
         cnt_r   <= (len_i == '0) ? '0 : len_i - cnt_width_lp'(1);
      end else if (cnt_r != '0) begin
         shift_o <= data_r[0];
         data_r  <= data_r >> 1;
         cnt_r   <= cnt_r - cnt_width_lp'(1);
      end else begin
         shift_o <= 1'b0;
      end
   end

   assign empty_o = (cnt_r == '0);

endmodule

// File: rtl/bsg_manycore_tag_boot_seq.sv
// Walks an external entry table after start_i and serialises each entry as a
// bsg_tag packet on tag_data_o, framed by a preamble and inter-packet gaps.
module bsg_manycore_tag_boot_seq
   import bsg_manycore_tag_boot_pkg::*;
 #(parameter int unsigned node_id_width_p     = tag_boot_node_id_width_lp
  ,parameter int unsigned max_payload_width_p = tag_boot_max_payload_width_lp
  ,parameter int unsigned lg_payload_width_p  = tag_boot_lg_payload_width_lp
  ,parameter int unsigned entries_p           = 32
  ,parameter int unsigned preamble_p          = 32
  ,parameter int unsigned gap_p               = 4
  ,localparam int unsigned entry_width_lp =
      2 + node_id_width_p + lg_payload_width_p + max_payload_width_p
  ,localparam int unsigned addr_width_lp  = (entries_p > 1) ? $clog2(entries_p) : 1
  )
  (input  logic                      clk_i
  ,input  logic                      reset_i
  ,input  logic                      start_i
  ,output logic [addr_width_lp-1:0]  rom_addr_o
  ,input  logic [entry_width_lp-1:0] rom_data_i
  ,output logic                      tag_data_o
  ,output logic                      busy_o
  ,output logic                      done_o
  ,output logic                      error_o
  );

   localparam int unsigned hdr_len_lp         = tag_boot_hdr_len(lg_payload_width_p, node_id_width_p);
   localparam int unsigned shift_width_lp     = tag_boot_max(hdr_len_lp, max_payload_width_p);
   localparam int unsigned shift_cnt_width_lp = $clog2(shift_width_lp + 1);
   localparam int unsigned field_max_lp       =
      tag_boot_max(tag_boot_max(preamble_p, hdr_len_lp), tag_boot_max(max_payload_width_p, gap_p));
   localparam int unsigned cnt_width_lp       = $clog2(field_max_lp + 1);

   // Entry fields straight off the table read port.
   logic [max_payload_width_p-1:0] entry_payload;
   logic [lg_payload_width_p-1:0]  entry_len;
   logic                           entry_dnr;
   logic [node_id_width_p-1:0]     entry_node;
   logic                           entry_last;
   logic                           entry_bad;
   logic [hdr_len_lp-1:0]          hdr_vec;

   assign {entry_last, entry_node, entry_dnr, entry_len, entry_payload} = rom_data_i;
   assign entry_bad = (32'(entry_len) > max_payload_width_p);
   // Bit 0 leaves first: start, len LSB-first, data_not_reset, node_id LSB-first.
   assign hdr_vec   = {entry_node, entry_dnr, entry_len, 1'b1};

   tag_boot_state_e                state_r, state_n;
   logic [cnt_width_lp-1:0]        cnt_r, cnt_n;
   logic [addr_width_lp-1:0]       addr_n;
   logic                           busy_n, done_n, error_n;
   logic [lg_payload_width_p-1:0]  len_r;
   logic [max_payload_width_p-1:0] payload_r;
   logic                           last_r;
   logic                           capture;
   logic                           advance;
   logic                           last_now;

   logic                           shf_load;
   logic [shift_width_lp-1:0]      shf_data;
   logic [shift_cnt_width_lp-1:0]  shf_len;
   logic                           shf_empty;

   bsg_manycore_tag_boot_shifter #(.width_p(shift_width_lp)) shifter
     (.clk_i   (clk_i)
     ,.reset_i (reset_i)
     ,.load_i  (shf_load)
     ,.data_i  (shf_data)
     ,.len_i   (shf_len)
     ,.shift_o (tag_data_o)
     ,.empty_o (shf_empty)
     );

   // A rejected entry decides "next" from its own last flag, still on the read port.
   assign last_now = (state_r == s_load) ? entry_last : last_r;

   // Next-state, counter, address and status decisions.
   always_comb begin
      state_n  = state_r;
      cnt_n    = cnt_r;
      addr_n   = rom_addr_o;
      busy_n   = busy_o;
      done_n   = done_o;
      error_n  = error_o;
      capture  = 1'b0;
      advance  = 1'b0;
      shf_load = 1'b0;
      shf_data = '0;
      shf_len  = '0;

      case (state_r)
         s_idle, s_done: begin
            if (start_i) begin
               state_n = s_pre;
               cnt_n   = cnt_width_lp'(preamble_p - 1);
               addr_n  = '0;
               busy_n  = 1'b1;
               done_n  = 1'b0;
               error_n = 1'b0;
            end
         end
         s_pre: begin
            if (cnt_r == '0) state_n = s_load;
            else             cnt_n   = cnt_r - cnt_width_lp'(1);
         end
         s_load: begin
            if (entry_bad) begin
               error_n = 1'b1;
               advance = 1'b1;
            end else begin
               capture  = 1'b1;
               shf_load = 1'b1;
               shf_data = shift_width_lp'(hdr_vec);
               shf_len  = shift_cnt_width_lp'(hdr_len_lp);
               state_n  = s_hdr;
            end
         end
         s_hdr: begin
            if (shf_empty) begin
               if (len_r != '0) begin
                  shf_load = 1'b1;
                  shf_data = shift_width_lp'(payload_r);
                  shf_len  = shift_cnt_width_lp'(len_r);
                  state_n  = s_pay;
               end else begin
                  state_n = s_gap;
                  cnt_n   = cnt_width_lp'(gap_p - 1);
               end
            end
         end
         s_pay: begin
            if (shf_empty) begin
               state_n = s_gap;
               cnt_n   = cnt_width_lp'(gap_p - 1);
            end
         end
         s_gap: begin
            if (cnt_r == '0) advance = 1'b1;
            else             cnt_n   = cnt_r - cnt_width_lp'(1);
         end
         default: state_n = s_idle;
      endcase

      if (advance) begin
         if (last_now || (rom_addr_o == addr_width_lp'(entries_p - 1))) begin
            state_n = s_done;
            addr_n  = '0;
            busy_n  = 1'b0;
            done_n  = 1'b1;
         end else begin
            state_n = s_load;
            addr_n  = rom_addr_o + addr_width_lp'(1);
         end
      end
   end

   // State, counters, status flags and the captured entry fields.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_r    <= s_idle;
         cnt_r      <= '0;
         rom_addr_o <= '0;
         busy_o     <= 1'b0;
         done_o     <= 1'b0;
         error_o    <= 1'b0;
         len_r      <= '0;
         payload_r  <= '0;
         last_r     <= 1'b0;
      end else begin
         state_r    <= state_n;
         cnt_r      <= cnt_n;
         rom_addr_o <= addr_n;
         busy_o     <= busy_n;
         done_o     <= done_n;
         error_o    <= error_n;
         if (capture) begin
            len_r     <= entry_len;
            payload_r <= entry_payload;
            last_r    <= entry_last;
         end
      end
   end

endmodule

// File: tb/tb_bsg_manycore_tag_boot_seq.sv
// Bench for the tag boot sequencer: random tables against a packet-level model.
module tb_bsg_manycore_tag_boot_seq;
   import bsg_manycore_tag_boot_pkg::*;

   localparam int unsigned preamble_lp = 32;
   localparam int unsigned gap_lp      = 4;
   localparam int unsigned entries_lp  = 32;
   localparam int unsigned max_len_lp  = 16;

   logic        clk = 1'b0;
   logic        reset_i;
   logic        start_i;
   logic [4:0]  rom_addr_o;
   logic [30:0] rom_data_i;
   logic        tag_data_o, busy_o, done_o, error_o;

   bsg_manycore_tag_boot_entry_s rom [entries_lp];
   logic [8:0]  exp_q [$];
   logic [8:0]  observed;
   int unsigned vectors     = 0;
   int unsigned miscompares = 0;

   assign rom_data_i = rom[rom_addr_o];
   assign observed   = {tag_data_o, busy_o, done_o, error_o, rom_addr_o};

   bsg_manycore_tag_boot_seq #(
      .node_id_width_p     (8),
      .max_payload_width_p (16),
      .lg_payload_width_p  (5),
      .entries_p           (32),
      .preamble_p          (32),
      .gap_p               (4)
   ) dut (
      .clk_i      (clk),
      .reset_i    (reset_i),
      .start_i    (start_i),
      .rom_addr_o (rom_addr_o),
      .rom_data_i (rom_data_i),
      .tag_data_o (tag_data_o),
      .busy_o     (busy_o),
      .done_o     (done_o),
      .error_o    (error_o)
   );

   initial forever #5 clk = ~clk;

   function automatic logic [8:0] v(input logic t, input logic b, input logic d,
                                    input logic er, input int unsigned a);
      return {t, b, d, er, 5'(a)};
   endfunction

   // Per-cycle expectation {tag, busy, done, error, addr}, starting with the
   // first cycle after start is accepted and ending with the first DONE cycle.
   function automatic void build_expected();
      logic err;
      bsg_manycore_tag_boot_entry_s e;
      err = 1'b0;
      exp_q.delete();
      repeat (preamble_lp) exp_q.push_back(v(1'b0, 1'b1, 1'b0, err, 0));
      for (int unsigned a = 0; a < entries_lp; a++) begin
         e = rom[a];
         exp_q.push_back(v(1'b0, 1'b1, 1'b0, err, a));
         if (32'(e.len) > max_len_lp) begin
            err = 1'b1;
         end else begin
            exp_q.push_back(v(1'b1, 1'b1, 1'b0, err, a));
            for (int unsigned i = 0; i < 5; i++) exp_q.push_back(v(e.len[i], 1'b1, 1'b0, err, a));
            exp_q.push_back(v(e.data_not_reset, 1'b1, 1'b0, err, a));
            for (int unsigned i = 0; i < 8; i++) exp_q.push_back(v(e.node_id[i], 1'b1, 1'b0, err, a));
            for (int unsigned i = 0; i < 32'(e.len); i++) exp_q.push_back(v(e.payload[i], 1'b1, 1'b0, err, a));
            repeat (gap_lp) exp_q.push_back(v(1'b0, 1'b1, 1'b0, err, a));
         end
         if (e.last) break;
      end
      exp_q.push_back(v(1'b0, 1'b0, 1'b1, err, 0));
   endfunction

   task automatic clear_rom();
      for (int unsigned a = 0; a < entries_lp; a++) rom[a] = '0;
   endtask

   task automatic fill_random(input bit allow_last, input bit allow_bad);
      bsg_manycore_tag_boot_entry_s e;
      for (int unsigned a = 0; a < entries_lp; a++) begin
         e.last           = allow_last && ($urandom_range(0, 7) == 0);
         e.node_id        = 8'($urandom);
         e.data_not_reset = 1'($urandom);
         e.len            = 5'(allow_bad ? $urandom_range(0, 20) : $urandom_range(0, 16));
         e.payload        = 16'($urandom);
         rom[a] = e;
      end
   endtask

   // Called at a negedge; returns at the negedge of the first cycle after acceptance.
   task automatic pulse_start();
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
   endtask

   task automatic test_reset();
      vectors++;
      if (observed !== 9'd0) begin
         miscompares++;
         $display("FAIL reset_held: got %b want %b", observed, 9'd0);
      end
      reset_i = 1'b0;
      repeat (3) @(negedge clk);
      vectors++;
      if (observed !== 9'd0) begin
         miscompares++;
         $display("FAIL reset_idle: got %b want %b", observed, 9'd0);
      end
   endtask

   task automatic test_single_entry();
      logic [17:0] bits;
      bits = '0;
      clear_rom();
      rom[0] = '{last: 1'b1, node_id: 8'd5, data_not_reset: 1'b1, len: 5'd3, payload: 16'b101};
      build_expected();
      pulse_start();
      foreach (exp_q[i]) begin
         vectors++;
         if (observed !== exp_q[i]) begin
            miscompares++;
            $display("FAIL single_entry cyc %0d: got %b want %b", i, observed, exp_q[i]);
         end
         if (i >= 33 && i <= 50) bits = {bits[16:0], tag_data_o};
         @(negedge clk);
      end
      vectors++;
      if (bits !== 18'b1_11000_1_10100000_101) begin
         miscompares++;
         $display("FAIL single_entry_bits: got %b want %b", bits, 18'b1_11000_1_10100000_101);
      end
   endtask

   task automatic test_zero_len_full_payload();
      logic [15:0] pay;
      pay = '0;
      clear_rom();
      rom[0] = '{last: 1'b0, node_id: 8'd2, data_not_reset: 1'b0, len: 5'd0, payload: 16'($urandom)};
      rom[1] = '{last: 1'b1, node_id: 8'($urandom), data_not_reset: 1'b1, len: 5'd16, payload: 16'hBEEF};
      build_expected();
      pulse_start();
      foreach (exp_q[i]) begin
         vectors++;
         if (observed !== exp_q[i]) begin
            miscompares++;
            $display("FAIL zero_len cyc %0d: got %b want %b", i, observed, exp_q[i]);
         end
         if (i >= 68 && i <= 83) pay[i - 68] = tag_data_o;
         @(negedge clk);
      end
      vectors++;
      if (pay !== 16'hBEEF) begin
         miscompares++;
         $display("FAIL beef_payload: got %h want %h", pay, 16'hBEEF);
      end
   endtask

   task automatic test_bad_len();
      fill_random(1'b0, 1'b0);
      rom[1].len  = 5'd20;
      rom[2].last = 1'b1;
      build_expected();
      pulse_start();
      foreach (exp_q[i]) begin
         vectors++;
         if (observed !== exp_q[i]) begin
            miscompares++;
            $display("FAIL bad_len cyc %0d: got %b want %b", i, observed, exp_q[i]);
         end
         @(negedge clk);
      end
      vectors++;
      if (error_o !== 1'b1) begin
         miscompares++;
         $display("FAIL bad_len_sticky: got %b want 1", error_o);
      end
   endtask

   task automatic test_no_last();
      fill_random(1'b0, 1'b0);
      build_expected();
      pulse_start();
      foreach (exp_q[i]) begin
         vectors++;
         if (observed !== exp_q[i]) begin
            miscompares++;
            $display("FAIL no_last cyc %0d: got %b want %b", i, observed, exp_q[i]);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_start_mid_hdr();
      int unsigned idx;
      fill_random(1'b1, 1'b1);
      rom[0].len = 5'($urandom_range(0, 16));
      idx = preamble_lp + 1 + $urandom_range(1, 14);
      build_expected();
      pulse_start();
      foreach (exp_q[i]) begin
         vectors++;
         if (observed !== exp_q[i]) begin
            miscompares++;
            $display("FAIL start_mid_hdr cyc %0d: got %b want %b", i, observed, exp_q[i]);
         end
         start_i = (32'(i) == idx);
         @(negedge clk);
      end
      start_i = 1'b0;
   endtask

   task automatic test_reset_mid_pay();
      int unsigned idx;
      fill_random(1'b1, 1'b1);
      rom[0].len  = 5'd16;
      rom[0].last = 1'b0;
      idx = preamble_lp + 1 + 15 + $urandom_range(0, 15);
      build_expected();
      pulse_start();
      foreach (exp_q[i]) begin
         vectors++;
         if (observed !== exp_q[i]) begin
            miscompares++;
            $display("FAIL pre_reset cyc %0d: got %b want %b", i, observed, exp_q[i]);
         end
         if (32'(i) == idx) break;
         @(negedge clk);
      end
      reset_i = 1'b1;
      @(negedge clk);
      vectors++;
      if (observed !== 9'd0) begin
         miscompares++;
         $display("FAIL reset_mid_pay: got %b want %b", observed, 9'd0);
      end
      reset_i = 1'b0;
      @(negedge clk);
      pulse_start();
      foreach (exp_q[i]) begin
         vectors++;
         if (observed !== exp_q[i]) begin
            miscompares++;
            $display("FAIL replay cyc %0d: got %b want %b", i, observed, exp_q[i]);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_back_to_back();
      for (int unsigned r = 0; r < 4; r++) begin
         fill_random(1'b1, 1'b1);
         build_expected();
         pulse_start();
         foreach (exp_q[i]) begin
            vectors++;
            if (observed !== exp_q[i]) begin
               miscompares++;
               $display("FAIL back_to_back run %0d cyc %0d: got %b want %b", r, i, observed, exp_q[i]);
            end
            @(negedge clk);
         end
      end
   endtask

   initial begin
      reset_i = 1'b1;
      start_i = 1'b0;
      clear_rom();
      repeat (3) @(negedge clk);
      test_reset();
      test_single_entry();
      test_zero_len_full_payload();
      test_bad_len();
      test_no_last();
      test_start_mid_hdr();
      test_reset_mid_pay();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
